// File: rtl/wb_write_sequencer_if.sv
// Writeback bus between the execution sources, the sequencer and decode.
// Optional bypass lookup signals are present only when WB_BYPASS_EN is defined.
`timescale 1ns/1ps

interface wb_write_sequencer_if #(
    parameter int unsigned NBITS      = 32,
    parameter int unsigned NREGISTERS = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RD_W  = 5;

    // ALU result channel
    logic                  alu_valid;
    logic                  alu_ready;
    logic [RD_W-1:0]       alu_rd;
    logic [NBITS-1:0]      alu_data;

    // LSU/MUL result channel
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [RD_W-1:0]       lsu_rd;
    logic [NBITS-1:0]      lsu_data;

    // Register file write port and hazard status
    logic                  rf_wr_en;
    logic [RD_W-1:0]       rf_add_wr;
    logic [NBITS-1:0]      rf_datain;
    logic [NREGISTERS-1:0] pending;
    logic [CNT_W-1:0]      count;

`ifdef WB_BYPASS_EN
    // Decode-side forwarding lookup
    logic [RD_W-1:0]       byp_addr1;
    logic [RD_W-1:0]       byp_addr2;
    logic                  byp_hit1;
    logic                  byp_hit2;
    logic [NBITS-1:0]      byp_data1;
    logic [NBITS-1:0]      byp_data2;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  rf_wr_en, rf_add_wr, rf_datain, pending, count,
        output byp_addr1, byp_addr2,
        input  byp_hit1, byp_hit2, byp_data1, byp_data2
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output rf_wr_en, rf_add_wr, rf_datain, pending, count,
        input  byp_addr1, byp_addr2,
        output byp_hit1, byp_hit2, byp_data1, byp_data2
    );
`else
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  rf_wr_en, rf_add_wr, rf_datain, pending, count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output rf_wr_en, rf_add_wr, rf_datain, pending, count
    );
`endif

endinterface

// File: rtl/wb_write_sequencer.sv
// Writeback sequencer: merges ALU and LSU/MUL results into an in-order FIFO
// and drains one register-file write per cycle through a registered stage.
// Define WB_BYPASS_EN to add the combinational forwarding lookup ports.
`timescale 1ns/1ps

module wb_write_sequencer #(
    parameter int unsigned NBITS      = 32,
    parameter int unsigned NREGISTERS = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_write_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned RD_W  = 5;
    localparam int unsigned NRD   = 1 << RD_W;

    typedef struct packed {
        logic [RD_W-1:0]  rd;
        logic [NBITS-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] alu_slot;
    logic [CNT_W-1:0] count_q;

    logic             rf_wr_en_q;
    logic [RD_W-1:0]  rf_add_wr_q;
    logic [NBITS-1:0] rf_datain_q;

    logic             alu_fire;
    logic             lsu_fire;
    logic             alu_push;
    logic             lsu_push;
    logic             pop;
    logic [NRD-1:0]   pend_all;

    // Ready is a function of registered occupancy only; ALU needs two free
    // slots so a same-edge LSU result always has room ahead of it.
    assign bus.lsu_ready = rst && (count_q < CNT_W'(DEPTH));
    assign bus.alu_ready = rst && (count_q <= CNT_W'(DEPTH - 2));

    // Accepted results to x0 complete the handshake but are not queued.
    assign lsu_fire = bus.lsu_valid && bus.lsu_ready;
    assign alu_fire = bus.alu_valid && bus.alu_ready;
    assign lsu_push = lsu_fire && (bus.lsu_rd != '0);
    assign alu_push = alu_fire && (bus.alu_rd != '0);
    assign pop      = (count_q != '0);

    // LSU is the older instruction, so it takes the first free slot.
    assign alu_slot = wr_ptr + PTR_W'(lsu_push);

    assign bus.rf_wr_en  = rf_wr_en_q;
    assign bus.rf_add_wr = rf_add_wr_q;
    assign bus.rf_datain = rf_datain_q;
    assign bus.count     = count_q;

    // FIFO storage; stale contents are masked by count so no reset needed.
    always_ff @(posedge clk) begin
        if (lsu_push) begin
            mem[wr_ptr] <= '{rd: bus.lsu_rd, data: bus.lsu_data};
        end
        if (alu_push) begin
            mem[alu_slot] <= '{rd: bus.alu_rd, data: bus.alu_data};
        end
    end

    // Pointers, occupancy and the register-file output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            rf_wr_en_q  <= 1'b0;
            rf_add_wr_q <= '0;
            rf_datain_q <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(lsu_push) + PTR_W'(alu_push);
            count_q    <= count_q + CNT_W'(lsu_push) + CNT_W'(alu_push) - CNT_W'(pop);
            rf_wr_en_q <= pop;
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                rf_add_wr_q <= mem[rd_ptr].rd;
                rf_datain_q <= mem[rd_ptr].data;
            end
        end
    end

    // Pending mask: every queued destination plus the write being presented.
    always_comb begin
        pend_all = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (CNT_W'(k) < count_q) begin
                pend_all[mem[rd_ptr + PTR_W'(k)].rd] = 1'b1;
            end
        end
        if (rf_wr_en_q) begin
            pend_all[rf_add_wr_q] = 1'b1;
        end
        pend_all[0] = 1'b0;
    end

    assign bus.pending = NREGISTERS'(pend_all);

`ifdef WB_BYPASS_EN
    logic             byp_hit1;
    logic             byp_hit2;
    logic [NBITS-1:0] byp_data1;
    logic [NBITS-1:0] byp_data2;
    entry_t           byp_e;

    // Forwarding lookup, scanned oldest to youngest so the youngest match wins.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        byp_e     = '0;
        if (rf_wr_en_q) begin
            if (rf_add_wr_q == bus.byp_addr1) begin
                byp_hit1  = 1'b1;
                byp_data1 = rf_datain_q;
            end
            if (rf_add_wr_q == bus.byp_addr2) begin
                byp_hit2  = 1'b1;
                byp_data2 = rf_datain_q;
            end
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (CNT_W'(k) < count_q) begin
                byp_e = mem[rd_ptr + PTR_W'(k)];
                if (byp_e.rd == bus.byp_addr1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = byp_e.data;
                end
                if (byp_e.rd == bus.byp_addr2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = byp_e.data;
                end
            end
        end
        if (bus.byp_addr1 == '0) begin
            byp_hit1  = 1'b0;
            byp_data1 = '0;
        end
        if (bus.byp_addr2 == '0) begin
            byp_hit2  = 1'b0;
            byp_data2 = '0;
        end
    end

    assign bus.byp_hit1  = byp_hit1;
    assign bus.byp_hit2  = byp_hit2;
    assign bus.byp_data1 = byp_data1;
    assign bus.byp_data2 = byp_data2;
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Bench for wb_write_sequencer: directed scenarios plus randomized traffic,
// all compared against a queue-based reference of the writeback rules.
`timescale 1ns/1ps

module tb_wb_write_sequencer;
    localparam int unsigned NBITS      = 32;
    localparam int unsigned NREGISTERS = 32;
    localparam int unsigned DEPTH      = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_write_sequencer_if #(.NBITS(NBITS), .NREGISTERS(NREGISTERS), .DEPTH(DEPTH)) bus ();

    wb_write_sequencer #(.NBITS(NBITS), .NREGISTERS(NREGISTERS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]       rd;
        logic [NBITS-1:0] data;
    } wr_t;

    // Reference: queue of accepted writes plus the presented write.
    wr_t              q[$];
    logic             m_en;
    logic [4:0]       m_addr;
    logic [NBITS-1:0] m_data;
    logic             alu_fire;
    logic             lsu_fire;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_lsu_ready();
        return rst && (q.size() < int'(DEPTH));
    endfunction

    function automatic logic exp_alu_ready();
        return rst && (q.size() <= int'(DEPTH) - 2);
    endfunction

    function automatic logic [NBITS:0] byp_ref(input logic [4:0] a);
        logic [NBITS:0] r;
        r = '0;
        if (a == 5'd0) return r;
        if (m_en && m_addr == a) r = {1'b1, m_data};
        foreach (q[i]) if (q[i].rd == a) r = {1'b1, q[i].data};
        return r;
    endfunction

    task automatic check_all();
        logic [31:0] ep;
        ep = '0;
        foreach (q[i]) ep[q[i].rd] = 1'b1;
        if (m_en) ep[m_addr] = 1'b1;
        ep[0] = 1'b0;
        check("count", bus.count, q.size());
        check("alu_ready", bus.alu_ready, exp_alu_ready());
        check("lsu_ready", bus.lsu_ready, exp_lsu_ready());
        check("rf_wr_en", bus.rf_wr_en, m_en);
        check("rf_add_wr", bus.rf_add_wr, m_addr);
        check("rf_datain", bus.rf_datain, m_data);
        check("pending", bus.pending, ep);
`ifdef WB_BYPASS_EN
        begin
            logic [NBITS:0] r1;
            logic [NBITS:0] r2;
            bus.byp_addr1 = 5'($urandom_range(0, 7));
            bus.byp_addr2 = 5'($urandom_range(0, 31));
            #1;
            r1 = byp_ref(bus.byp_addr1);
            r2 = byp_ref(bus.byp_addr2);
            check("byp_hit1", bus.byp_hit1, r1[NBITS]);
            check("byp_data1", bus.byp_data1, r1[NBITS-1:0]);
            check("byp_hit2", bus.byp_hit2, r2[NBITS]);
            check("byp_data2", bus.byp_data2, r2[NBITS-1:0]);
        end
`endif
    endtask

    // One clock: decide acceptances, advance the reference, then check.
    task automatic tick();
        wr_t h;
        alu_fire = bus.alu_valid && exp_alu_ready();
        lsu_fire = bus.lsu_valid && exp_lsu_ready();
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_en     = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            alu_fire = 1'b0;
            lsu_fire = 1'b0;
        end else begin
            if (q.size() > 0) begin
                h      = q.pop_front();
                m_en   = 1'b1;
                m_addr = h.rd;
                m_data = h.data;
            end else begin
                m_en = 1'b0;
            end
            if (lsu_fire && bus.lsu_rd != 5'd0) q.push_back('{bus.lsu_rd, bus.lsu_data});
            if (alu_fire && bus.alu_rd != 5'd0) q.push_back('{bus.alu_rd, bus.alu_data});
        end
        @(negedge clk);
        check_all();
    endtask

    // Offers hold a stalled transfer unchanged until it is accepted.
    task automatic offer_alu(input logic v, input logic [4:0] rd, input logic [NBITS-1:0] d);
        if (bus.alu_valid && !alu_fire) return;
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic offer_lsu(input logic v, input logic [4:0] rd, input logic [NBITS-1:0] d);
        if (bus.lsu_valid && !lsu_fire) return;
        bus.lsu_valid = v;
        bus.lsu_rd    = rd;
        bus.lsu_data  = d;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            offer_alu(1'b0, '0, '0);
            offer_lsu(1'b0, '0, '0);
            tick();
        end
    endtask

    function automatic logic [4:0] rand_rd();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    a_alu_hold: assert property (@(posedge clk) disable iff (!rst)
        (bus.alu_valid && !bus.alu_ready) |=>
        (bus.alu_valid && $stable(bus.alu_rd) && $stable(bus.alu_data)))
        else $error("FAIL alu_hold: ALU valid/data changed while stalled");

    a_lsu_hold: assert property (@(posedge clk) disable iff (!rst)
        (bus.lsu_valid && !bus.lsu_ready) |=>
        (bus.lsu_valid && $stable(bus.lsu_rd) && $stable(bus.lsu_data)))
        else $error("FAIL lsu_hold: LSU valid/data changed while stalled");

    initial begin
        rst           = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_data  = '0;
`ifdef WB_BYPASS_EN
        bus.byp_addr1 = '0;
        bus.byp_addr2 = '0;
`endif
        alu_fire = 1'b0;
        lsu_fire = 1'b0;
        m_en     = 1'b0;
        m_addr   = '0;
        m_data   = '0;

        do_reset();
        check("reset_count", bus.count, 0);
        check("reset_wr_en", bus.rf_wr_en, 0);
        idle(2);

        // Single ALU result: presented one cycle after the accepting edge.
        offer_alu(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check("alu5_pending", bus.pending[5], 1);
        idle(1);
        check("alu5_wr_en", bus.rf_wr_en, 1);
        check("alu5_addr", bus.rf_add_wr, 5);
        check("alu5_data", bus.rf_datain, 32'hDEADBEEF);
        idle(1);
        check("alu5_done_en", bus.rf_wr_en, 0);
        check("alu5_done_pend", bus.pending, 0);

        // Same-edge LSU and ALU to one register: LSU first, ALU wins.
        offer_lsu(1'b1, 5'd3, 32'h11);
        offer_alu(1'b1, 5'd3, 32'h22);
        tick();
        idle(1);
        check("order_first", bus.rf_datain, 32'h11);
        idle(1);
        check("order_second", bus.rf_datain, 32'h22);
        check("order_pend_hold", bus.pending[3], 1);
        idle(1);
        check("order_pend_clr", bus.pending[3], 0);
        idle(2);

        // Back-to-back pairs push occupancy to the ALU-stall point.
        for (int i = 0; i < 4; i++) begin
            offer_lsu(1'b1, 5'(8 + i), $urandom);
            offer_alu(1'b1, 5'(16 + i), $urandom);
            tick();
            if (i == 1) begin
                check("fill_count3", bus.count, 3);
                check("fill_alu_stall", bus.alu_ready, 0);
                check("fill_lsu_ok", bus.lsu_ready, 1);
            end
        end
        idle(8);

        // x0 result is accepted and discarded.
        offer_alu(1'b1, 5'd0, 32'hFFFFFFFF);
        check("x0_ready", bus.alu_ready, 1);
        tick();
        check("x0_count", bus.count, 0);
        idle(1);
        check("x0_wr_en", bus.rf_wr_en, 0);
        check("x0_pending", bus.pending, 0);

        // Mid-operation reset discards three queued writes.
        offer_lsu(1'b1, 5'd9, 32'h900);
        offer_alu(1'b1, 5'd10, 32'hA00);
        tick();
        offer_lsu(1'b1, 5'd11, 32'hB00);
        offer_alu(1'b1, 5'd12, 32'hC00);
        tick();
        check("pre_rst_count", bus.count, 3);
        do_reset();
        check("rst_mid_count", bus.count, 0);
        check("rst_mid_pending", bus.pending, 0);
        check("rst_mid_wr_en", bus.rf_wr_en, 0);
        idle(4);

`ifdef WB_BYPASS_EN
        // Youngest matching entry is forwarded; x0 never hits.
        offer_alu(1'b1, 5'd7, 32'hA);
        tick();
        offer_alu(1'b1, 5'd7, 32'hB);
        tick();
        bus.byp_addr1 = 5'd7;
        bus.byp_addr2 = 5'd0;
        #1;
        check("byp7_hit", bus.byp_hit1, 1);
        check("byp7_data", bus.byp_data1, 32'hB);
        check("byp0_hit", bus.byp_hit2, 0);
        idle(4);
`endif

        // Randomized traffic with occasional mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                offer_lsu($urandom_range(0, 99) < 55, rand_rd(), $urandom);
                offer_alu($urandom_range(0, 99) < 60, rand_rd(), $urandom);
                tick();
            end
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
